// File: rtl/riscblade_pkg.sv
// Shared types and default widths for the riscblade 16-bit multicycle core.
//   fetch_state_t   : fetch front-end sequencing states
//   DEFAULT_*       : default parameter values for fetch_unit
package riscblade_pkg;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
   } fetch_state_t;

   localparam int unsigned DEFAULT_ADDR_W  = 16;
   localparam int unsigned DEFAULT_INSTR_W = 16;
   localparam int unsigned DEFAULT_PC_STEP = 2;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch front end.
//   clock, reset    : clock, asynchronous active-high reset (loads RESET_VECTOR)
//   grant           : request accepted this cycle -> advance by PC_STEP
//   redirect_en     : load redirect_addr (aligned); wins over grant
//   redirect_addr   : redirect target, low log2(PC_STEP) bits ignored
//   pc              : current fetch address
module fetch_pc_reg #(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned PC_STEP      = 2,
   parameter int unsigned RESET_VECTOR = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              grant,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] pc
);

   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));

   logic [ADDR_W-1:0] r_pc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc <= ADDR_W'(RESET_VECTOR);
      end else if (redirect_en) begin
         r_pc <= redirect_addr & ALIGN_MASK;
      end else if (grant) begin
         r_pc <= r_pc + STEP;   // wraps modulo 2^ADDR_W
      end
   end

   assign pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues fetches over a
// req/gnt/rvalid handshake, holds the returned word for decode, and
// squashes in-flight fetches on redirect.
//   clock, reset             : clock, asynchronous active-high reset
//   mem_req/mem_addr/mem_gnt : fetch request, address (= pc), accept
//   mem_rdata/mem_rvalid     : returned word and its strobe
//   instr/instr_pc           : instruction register and its fetch address
//   instr_valid/instr_ready  : handshake to decode
//   redirect_en/addr         : load new PC, squash current fetch
//   pc                       : next fetch address
//   fetch_count              : instructions delivered (wraps)
module fetch_unit
   import riscblade_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
   parameter int unsigned INSTR_W      = DEFAULT_INSTR_W,
   parameter int unsigned PC_STEP      = DEFAULT_PC_STEP,
   parameter int unsigned RESET_VECTOR = 0,
   parameter int unsigned COUNT_W      = 16
) (
   input  logic               clock,
   input  logic               reset,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_gnt,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               mem_rvalid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect_en,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic [ADDR_W-1:0]  pc,
   output logic [COUNT_W-1:0] fetch_count
);

   fetch_state_t       r_state, w_state_nxt;
   logic               r_squash, w_squash_nxt;
   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_instr_pc;
   logic               r_instr_valid, w_valid_nxt;
   logic [COUNT_W-1:0] r_fetch_count;
   logic               w_grant, w_capture, w_count_inc;
   logic [ADDR_W-1:0]  w_pc;

   assign mem_req  = (r_state == S_REQ) & ~redirect_en & ~reset;
   assign w_grant  = mem_req & mem_gnt;
   assign mem_addr = w_pc;

   fetch_pc_reg #(
      .ADDR_W       (ADDR_W),
      .PC_STEP      (PC_STEP),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pc (
      .clock         (clock),
      .reset         (reset),
      .grant         (w_grant),
      .redirect_en   (redirect_en),
      .redirect_addr (redirect_addr),
      .pc            (w_pc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_REQ;
         r_squash      <= 1'b0;
         r_fetch_pc    <= '0;
         r_instr       <= '0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
         r_fetch_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_squash      <= w_squash_nxt;
         r_instr_valid <= w_valid_nxt;
         if (w_grant) r_fetch_pc <= w_pc;
         if (w_capture) begin
            r_instr    <= mem_rdata;
            r_instr_pc <= r_fetch_pc;
         end
         if (w_count_inc) r_fetch_count <= r_fetch_count + COUNT_W'(1);
      end
   end

   // Redirect is checked first in every state so it overrides grant,
   // capture and consume in the same cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_squash_nxt = r_squash;
      w_valid_nxt  = r_instr_valid;
      w_capture    = 1'b0;
      w_count_inc  = 1'b0;
      case (r_state)
         S_REQ: begin
            // rvalid deliberately ignored: any response here is stale
            if (w_grant) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               if (redirect_en || r_squash) begin
                  w_squash_nxt = 1'b0;
                  w_state_nxt  = S_REQ;
               end else begin
                  w_capture   = 1'b1;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end else if (redirect_en) begin
               w_squash_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect_en) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = S_REQ;
            end else if (instr_ready) begin
               w_valid_nxt = 1'b0;
               w_count_inc = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_REQ;
      endcase
   end

   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_instr_valid;
   assign pc          = w_pc;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_en;
   logic [15:0] redirect_addr;
   logic [15:0] pc;
   logic [15:0] fetch_count;

   int unsigned passed = 0;
   int unsigned total  = 0;

   fetch_unit #(
      .ADDR_W       (16),
      .INSTR_W      (16),
      .PC_STEP      (2),
      .RESET_VECTOR (0),
      .COUNT_W      (16)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_gnt       (mem_gnt),
      .mem_rdata     (mem_rdata),
      .mem_rvalid    (mem_rvalid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .redirect_en   (redirect_en),
      .redirect_addr (redirect_addr),
      .pc            (pc),
      .fetch_count   (fetch_count)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   initial begin
      reset = 1'b1; mem_gnt = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
      instr_ready = 1'b0; redirect_en = 1'b0; redirect_addr = '0;
      tick(); tick();
      chk("rst_req",   32'(mem_req), 0);
      chk("rst_pc",    32'(pc), 0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_count", 32'(fetch_count), 0);
      chk("rst_instr", 32'(instr), 0);
      reset = 1'b0; #1;

      // back-to-back fetches with minimum latency, decode always ready
      chk("t1_req",  32'(mem_req), 1);
      chk("t1_addr", 32'(mem_addr), 32'h0000);
      mem_gnt = 1'b1; instr_ready = 1'b1;
      tick();
      chk("t1_pc_after_gnt", 32'(pc), 32'h0002);
      chk("t1_wait_noreq", 32'(mem_req), 0);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1234;
      tick();
      chk("t1_v0",  32'(instr_valid), 1);
      chk("t1_i0",  32'(instr), 32'h1234);
      chk("t1_ip0", 32'(instr_pc), 32'h0000);
      mem_rvalid = 1'b0;
      tick();
      chk("t1_cnt1", 32'(fetch_count), 1);
      chk("t1_addr1", 32'(mem_addr), 32'h0002);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h5678;
      tick();
      chk("t1_i1",  32'(instr), 32'h5678);
      chk("t1_ip1", 32'(instr_pc), 32'h0002);
      mem_rvalid = 1'b0;
      tick();
      chk("t1_pc",  32'(pc), 32'h0004);
      chk("t1_cnt", 32'(fetch_count), 2);
      instr_ready = 1'b0;

      // grant stalled 3 cycles, response delayed 4 cycles
      reset = 1'b1; #1;
      chk("t2_rst_count", 32'(fetch_count), 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_stall_req",  32'(mem_req), 1);
         chk("t2_stall_addr", 32'(mem_addr), 32'h0000);
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t2_wait_valid", 32'(instr_valid), 0);
         tick();
      end
      mem_rvalid = 1'b1; mem_rdata = 16'hBEEF; #1;
      chk("t2_valid_at_rvalid", 32'(instr_valid), 0);
      tick();
      chk("t2_valid_after", 32'(instr_valid), 1);
      chk("t2_instr", 32'(instr), 32'hBEEF);
      mem_rvalid = 1'b0; instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("t2_cnt", 32'(fetch_count), 1);

      // redirect during S_WAIT squashes the in-flight response
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; redirect_en = 1'b1; redirect_addr = 16'h0041;
      tick();
      chk("t3_pc_aligned", 32'(pc), 32'h0040);
      redirect_en = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
      tick();
      mem_rvalid = 1'b0;
      chk("t3_dropped_valid", 32'(instr_valid), 0);
      chk("t3_instr_kept", 32'(instr), 32'hBEEF);
      chk("t3_req", 32'(mem_req), 1);
      chk("t3_addr", 32'(mem_addr), 32'h0040);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h1111;
      tick();
      mem_rvalid = 1'b0;
      chk("t3_ip", 32'(instr_pc), 32'h0040);
      chk("t3_instr", 32'(instr), 32'h1111);

      // redirect in S_HOLD together with instr_ready: no count
      instr_ready = 1'b1; redirect_en = 1'b1; redirect_addr = 16'h0100;
      tick();
      instr_ready = 1'b0; redirect_en = 1'b0;
      chk("t4_valid", 32'(instr_valid), 0);
      chk("t4_cnt", 32'(fetch_count), 1);
      chk("t4_addr", 32'(mem_addr), 32'h0100);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h2222;
      tick();
      mem_rvalid = 1'b0;
      chk("t4_ip", 32'(instr_pc), 32'h0100);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("t4_cnt2", 32'(fetch_count), 2);

      // redirect to top of memory, pc wraps after grant
      redirect_en = 1'b1; redirect_addr = 16'hFFFE; mem_gnt = 1'b1; #1;
      chk("t5_req_masked", 32'(mem_req), 0);
      tick();
      redirect_en = 1'b0;
      chk("t5_pc", 32'(pc), 32'hFFFE);
      tick();
      mem_gnt = 1'b0;
      chk("t5_wrap", 32'(pc), 32'h0000);
      mem_rvalid = 1'b1; mem_rdata = 16'h3333;
      tick();
      mem_rvalid = 1'b0;
      chk("t5_ip", 32'(instr_pc), 32'hFFFE);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("t5_cnt", 32'(fetch_count), 3);

      // async reset during S_WAIT, late response ignored
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("t6_pc_pre", 32'(pc), 32'h0002);
      #2 reset = 1'b1; #1;
      chk("t6_rst_pc", 32'(pc), 0);
      chk("t6_rst_cnt", 32'(fetch_count), 0);
      chk("t6_rst_instr", 32'(instr), 0);
      chk("t6_rst_ip", 32'(instr_pc), 0);
      chk("t6_rst_req", 32'(mem_req), 0);
      tick();
      reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h4444;
      tick();
      mem_rvalid = 1'b0;
      chk("t6_ignored_valid", 32'(instr_valid), 0);
      chk("t6_ignored_instr", 32'(instr), 0);
      chk("t6_req", 32'(mem_req), 1);
      chk("t6_addr", 32'(mem_addr), 32'h0000);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'h5555;
      tick();
      mem_rvalid = 1'b0;
      chk("t6_instr", 32'(instr), 32'h5555);
      chk("t6_ip", 32'(instr_pc), 32'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
